// File: rtl/dmem_mmio_pkg.sv
// Shared constants for the data-memory / MMIO stage: address decode fields,
// MMIO register offsets and timer control bit positions.
package dmem_mmio_pkg;

  // Address bit that separates RAM (0) from the peripheral block (1)
  localparam int MMIO_SEL_BIT = 31;

  // MMIO register offset field lives in Addr[7:2]
  localparam int OFS_LSB = 2;
  localparam int OFS_W   = 6;

  typedef logic [OFS_W-1:0] mmio_ofs_t;

  // Word offsets inside the peripheral block
  localparam mmio_ofs_t GPIO_OUT_OFS = 6'd0;
  localparam mmio_ofs_t GPIO_IN_OFS  = 6'd1;
  localparam mmio_ofs_t TCOUNT_OFS   = 6'd2;
  localparam mmio_ofs_t TCMP_OFS     = 6'd3;
  localparam mmio_ofs_t TCTRL_OFS    = 6'd4;

  // TIMER_CTRL bit positions
  localparam int EN_BIT      = 0;
  localparam int AUTOCLR_BIT = 1;
  localparam int PEND_BIT    = 2;

  // Per-register write strobes produced by the address decoder
  typedef struct packed {
    logic gpio_out;
    logic tcount;
    logic tcmp;
    logic tctrl;
  } mmio_wr_t;

endpackage

// File: rtl/dmem_mmio_timer.sv
// Compare timer: free-running COUNT with CMP match, optional auto-clear,
// sticky PEND flag (write-1-to-clear) and a registered interrupt output.
module mmio_timer
  import dmem_mmio_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_count,
  input  logic        wr_cmp,
  input  logic        wr_ctrl,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] cmp,
  output logic [31:0] ctrl,
  output logic        irq
);

  logic [31:0] count_q, count_d;
  logic [31:0] cmp_q, cmp_d;
  logic        en_q, en_d;
  logic        autoclr_q, autoclr_d;
  logic        pend_q, pend_d;
  logic        irq_q, irq_d;
  logic        match;

  // Next-state: a COUNT write beats the match/increment path; a match sets
  // PEND even when the same cycle carries a W1C of PEND.
  always_comb begin
    match     = en_q && (count_q == cmp_q);
    count_d   = count_q;
    cmp_d     = cmp_q;
    en_d      = en_q;
    autoclr_d = autoclr_q;
    pend_d    = pend_q;
    irq_d     = pend_q;

    if (wr_count) begin
      count_d = wdata;
    end else if (match) begin
      count_d = autoclr_q ? 32'd0 : count_q + 32'd1;
    end else if (en_q) begin
      count_d = count_q + 32'd1;
    end

    if (wr_cmp) begin
      cmp_d = wdata;
    end

    if (wr_ctrl) begin
      en_d      = wdata[EN_BIT];
      autoclr_d = wdata[AUTOCLR_BIT];
    end

    if (match) begin
      pend_d = 1'b1;
    end else if (wr_ctrl && wdata[PEND_BIT]) begin
      pend_d = 1'b0;
    end
  end

  // Timer state; everything clears asynchronously so a reset mid-count
  // leaves the timer stopped until EN is written again.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q   <= '0;
      cmp_q     <= '0;
      en_q      <= 1'b0;
      autoclr_q <= 1'b0;
      pend_q    <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      count_q   <= count_d;
      cmp_q     <= cmp_d;
      en_q      <= en_d;
      autoclr_q <= autoclr_d;
      pend_q    <= pend_d;
      irq_q     <= irq_d;
    end
  end

  // Pack the control bits into their register view for the read mux
  always_comb begin
    ctrl              = '0;
    ctrl[EN_BIT]      = en_q;
    ctrl[AUTOCLR_BIT] = autoclr_q;
    ctrl[PEND_BIT]    = pend_q;
  end

  assign count = count_q;
  assign cmp   = cmp_q;
  assign irq   = irq_q;

endmodule

// File: rtl/dmem_mmio.sv
// Data-memory stage: word RAM below 0x8000_0000, peripheral block (GPIO,
// synchronized GPIO input, compare timer) above. Loads are combinational.
module dmem_mmio
  import dmem_mmio_pkg::*;
#(
  parameter int RAM_WORDS = 64,
  parameter int GPIO_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemWrite,
  input  logic [31:0]       Addr,
  input  logic [31:0]       WriteData,
  output logic [31:0]       ReadData,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic [GPIO_W-1:0] gpio_out,
  output logic              timer_irq
);

  localparam int AW = $clog2(RAM_WORDS);

  logic [31:0]       ram_q [RAM_WORDS];
  logic [AW-1:0]     ram_idx;
  logic              ram_we;
  logic              is_mmio;
  mmio_ofs_t         ofs;
  mmio_wr_t          wr;

  logic [GPIO_W-1:0] gpio_out_q, gpio_out_d;
  logic [GPIO_W-1:0] sync1_q, sync1_d;
  logic [GPIO_W-1:0] sync2_q, sync2_d;

  logic [31:0]       t_count;
  logic [31:0]       t_cmp;
  logic [31:0]       t_ctrl;

  // Address bits with no function in this map; upper RAM bits simply alias
  logic              unused_addr;
  assign unused_addr = ^{Addr[30:8], Addr[1:0]};

  // Decode the address into RAM index, MMIO offset and per-register strobes
  always_comb begin
    is_mmio     = Addr[MMIO_SEL_BIT];
    ofs         = Addr[OFS_LSB +: OFS_W];
    ram_idx     = Addr[AW+1:2];
    ram_we      = MemWrite && !is_mmio;
    wr          = '0;
    wr.gpio_out = MemWrite && is_mmio && (ofs == GPIO_OUT_OFS);
    wr.tcount   = MemWrite && is_mmio && (ofs == TCOUNT_OFS);
    wr.tcmp     = MemWrite && is_mmio && (ofs == TCMP_OFS);
    wr.tctrl    = MemWrite && is_mmio && (ofs == TCTRL_OFS);
  end

  // Word RAM: full-word stores, contents deliberately left unreset
  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram_q[ram_idx] <= WriteData;
    end
  end

  // Next values for the GPIO output register and the input synchronizer
  always_comb begin
    gpio_out_d = wr.gpio_out ? WriteData[GPIO_W-1:0] : gpio_out_q;
    sync1_d    = gpio_in;
    sync2_d    = sync1_q;
  end

  // GPIO state; the two-flop chain tames metastability on gpio_in
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gpio_out_q <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
    end else begin
      gpio_out_q <= gpio_out_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
    end
  end

  mmio_timer u_timer (
    .clk      (clk),
    .reset    (reset),
    .wr_count (wr.tcount),
    .wr_cmp   (wr.tcmp),
    .wr_ctrl  (wr.tctrl),
    .wdata    (WriteData),
    .count    (t_count),
    .cmp      (t_cmp),
    .ctrl     (t_ctrl),
    .irq      (timer_irq)
  );

  // Combinational load path; unmapped MMIO offsets read as zero
  always_comb begin
    ReadData = '0;
    if (!is_mmio) begin
      ReadData = ram_q[ram_idx];
    end else begin
      case (ofs)
        GPIO_OUT_OFS: ReadData = 32'(gpio_out_q);
        GPIO_IN_OFS:  ReadData = 32'(sync2_q);
        TCOUNT_OFS:   ReadData = t_count;
        TCMP_OFS:     ReadData = t_cmp;
        TCTRL_OFS:    ReadData = t_ctrl;
        default:      ReadData = '0;
      endcase
    end
  end

  assign gpio_out = gpio_out_q;

endmodule

// File: tb/tb_dmem_mmio.sv
// Bench for dmem_mmio: directed scenarios followed by random traffic, all
// checked against a register-level reference model of the memory map.
module tb_dmem_mmio;

  localparam int RAM_WORDS = 64;
  localparam int GPIO_W    = 16;

  localparam logic [31:0] A_GOUT  = 32'h8000_0000;
  localparam logic [31:0] A_GIN   = 32'h8000_0004;
  localparam logic [31:0] A_TCNT  = 32'h8000_0008;
  localparam logic [31:0] A_TCMP  = 32'h8000_000C;
  localparam logic [31:0] A_TCTRL = 32'h8000_0010;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              MemWrite = 1'b0;
  logic [31:0]       Addr = '0;
  logic [31:0]       WriteData = '0;
  logic [31:0]       ReadData;
  logic [GPIO_W-1:0] gpio_in = '0;
  logic [GPIO_W-1:0] gpio_out;
  logic              timer_irq;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  logic [31:0] m_ram [RAM_WORDS];
  logic [15:0] m_gout, m_s1, m_s2;
  logic [31:0] m_cnt, m_cmp;
  logic        m_en, m_ac, m_pend, m_irq;

  always #5 clk = ~clk;

  dmem_mmio #(.RAM_WORDS(RAM_WORDS), .GPIO_W(GPIO_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .MemWrite  (MemWrite),
    .Addr      (Addr),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .gpio_in   (gpio_in),
    .gpio_out  (gpio_out),
    .timer_irq (timer_irq)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [31:0] a);
    if (!a[31]) return m_ram[a[7:2]];
    case (a[7:2])
      6'd0:    return {16'h0, m_gout};
      6'd1:    return {16'h0, m_s2};
      6'd2:    return m_cnt;
      6'd3:    return m_cmp;
      6'd4:    return {29'h0, m_pend, m_ac, m_en};
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_gout = '0; m_s1 = '0; m_s2 = '0;
    m_cnt = '0; m_cmp = '0;
    m_en = 1'b0; m_ac = 1'b0; m_pend = 1'b0; m_irq = 1'b0;
  endtask

  // One rising edge of the memory map, all updates from pre-edge values
  task automatic model_edge(input logic we, input logic [31:0] a, input logic [31:0] wd);
    logic        hit, match;
    logic [5:0]  o;
    logic [31:0] n_cnt;
    logic        n_pend;
    if (reset) begin
      model_reset();
      return;
    end
    hit   = we && a[31];
    o     = a[7:2];
    match = m_en && (m_cnt == m_cmp);
    if (hit && o == 6'd2)  n_cnt = wd;
    else if (match && m_ac) n_cnt = 32'd0;
    else if (m_en)          n_cnt = m_cnt + 32'd1;
    else                    n_cnt = m_cnt;
    if (match)                        n_pend = 1'b1;
    else if (hit && o == 6'd4 && wd[2]) n_pend = 1'b0;
    else                              n_pend = m_pend;
    m_irq  = m_pend;
    m_pend = n_pend;
    m_cnt  = n_cnt;
    if (hit && o == 6'd3) m_cmp = wd;
    if (hit && o == 6'd4) begin m_en = wd[0]; m_ac = wd[1]; end
    if (hit && o == 6'd0) m_gout = wd[15:0];
    m_s2 = m_s1;
    m_s1 = gpio_in;
    if (we && !a[31]) m_ram[a[7:2]] = wd;
  endtask

  // One bus cycle: drive, check the load mid-cycle, clock, check outputs
  task automatic step(input logic we, input logic [31:0] a, input logic [31:0] wd,
                      input bit chk, input bit use_lit, input logic [31:0] lit,
                      input string tag);
    MemWrite = we; Addr = a; WriteData = wd;
    @(negedge clk);
    if (chk) check({tag, "_rd"}, ReadData, m_read(a));
    if (use_lit) check({tag, "_lit"}, ReadData, lit);
    @(posedge clk);
    model_edge(we, a, wd);
    #1;
    check({tag, "_gout"}, {16'h0, gpio_out}, {16'h0, m_gout});
    check({tag, "_irq"}, {31'h0, timer_irq}, {31'h0, m_irq});
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] wd, input string tag);
    step(1'b1, a, wd, 1'b1, 1'b0, 32'h0, tag);
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] lit, input string tag);
    step(1'b0, a, 32'h0, 1'b1, 1'b1, lit, tag);
  endtask

  initial begin
    logic [31:0] a, wd;
    logic        we;

    model_reset();
    // Reset state, asserted between edges
    #1 reset = 1'b1;
    Addr = A_TCNT;
    #1;
    check("rst_gout", {16'h0, gpio_out}, 32'h0);
    check("rst_irq", {31'h0, timer_irq}, 32'h0);
    check("rst_count", ReadData, 32'h0);
    // MMIO store while in reset must be ignored
    step(1'b1, A_GOUT, 32'hFFFF, 1'b1, 1'b0, 32'h0, "rst_wr");
    reset = 1'b0;
    rd(A_GOUT, 32'h0, "rst_gout_rd");

    // Fill RAM so every word is known to the model
    for (int i = 0; i < RAM_WORDS; i++)
      step(1'b1, 32'(i * 4), $urandom, 1'b0, 1'b0, 32'h0, "preload");

    // RAM store, load, alias, neighbour, and read-during-write
    wr(32'h0000_0010, 32'hDEAD_BEEF, "ram_st");
    rd(32'h0000_0010, 32'hDEAD_BEEF, "ram_ld");
    rd(32'h0000_0110, 32'hDEAD_BEEF, "ram_alias");
    rd(32'h0000_0014, m_ram[5], "ram_nbr");
    wr(32'h0000_0020, 32'h1111_2222, "ram_rdw");
    rd(32'h0000_0020, 32'h1111_2222, "ram_rdw_new");

    // GPIO out and the two-edge input synchronizer
    wr(A_GOUT, 32'h0000_A5A5, "gout_wr");
    check("gout_lit", {16'h0, gpio_out}, 32'h0000_A5A5);
    gpio_in = 16'h1234;
    rd(A_GIN, 32'h0, "gin_e0");
    rd(A_GIN, 32'h0, "gin_e1");
    rd(A_GIN, 32'h1234, "gin_e2");

    // Timer match with auto-clear
    wr(A_TCMP, 32'd5, "tm_cmp");
    wr(A_TCTRL, 32'h3, "tm_ctrl");
    for (int i = 0; i < 6; i++) rd(A_TCNT, 32'(i), "tm_cnt");
    check("tm_irq_lag", {31'h0, timer_irq}, 32'h0);
    rd(A_TCNT, 32'h0, "tm_wrap0");
    check("tm_irq_set", {31'h0, timer_irq}, 32'h1);
    rd(A_TCTRL, 32'h7, "tm_pend");
    wr(A_TCTRL, 32'h7, "tm_w1c");
    rd(A_TCTRL, 32'h3, "tm_cleared");

    // COUNT write beats a match; match still sets PEND
    wr(A_TCTRL, 32'h4, "pr_stop");
    wr(A_TCMP, 32'h20, "pr_cmp");
    wr(A_TCNT, 32'h20, "pr_cnt");
    wr(A_TCTRL, 32'h1, "pr_en");
    wr(A_TCNT, 32'h100, "pr_load");
    rd(A_TCNT, 32'h100, "pr_cnt_rd");
    rd(A_TCTRL, 32'h5, "pr_pend");
    // Match beats a same-cycle W1C
    wr(A_TCTRL, 32'h4, "w1_stop");
    wr(A_TCNT, 32'h20, "w1_cnt");
    wr(A_TCTRL, 32'h1, "w1_en");
    wr(A_TCTRL, 32'h5, "w1_clr_match");
    rd(A_TCTRL, 32'h5, "w1_pend");

    // 32-bit wrap without a match
    wr(A_TCTRL, 32'h4, "wr_stop");
    wr(A_TCMP, 32'd7, "wr_cmp");
    wr(A_TCNT, 32'hFFFF_FFFF, "wr_cnt");
    wr(A_TCTRL, 32'h1, "wr_en");
    rd(A_TCNT, 32'hFFFF_FFFF, "wr_max");
    rd(A_TCNT, 32'h0, "wr_zero");
    rd(A_TCTRL, 32'h1, "wr_nopend");

    // Asynchronous reset mid-cycle with the timer running
    wr(A_GOUT, 32'hFFFF, "ar_gout");
    MemWrite = 1'b0; Addr = A_TCNT;
    @(negedge clk);
    reset = 1'b1;
    #1;
    model_reset();
    check("ar_gout0", {16'h0, gpio_out}, 32'h0);
    check("ar_irq0", {31'h0, timer_irq}, 32'h0);
    check("ar_cnt0", ReadData, 32'h0);
    @(posedge clk);
    model_edge(1'b0, A_TCNT, 32'h0);
    #1;
    reset = 1'b0;
    rd(A_TCNT, 32'h0, "ar_stop0");
    rd(A_TCNT, 32'h0, "ar_stop1");
    rd(32'h8000_0040, 32'h0, "unmapped");

    // Random traffic over RAM and MMIO
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) == 0) gpio_in = 16'($urandom);
      we = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 0)
        a = {1'b0, 31'($urandom)};
      else
        a = {1'b1, 23'($urandom), 3'($urandom_range(0, 7)) == 3'd7 ? 6'd33 : 6'($urandom_range(0, 5)), 2'($urandom)};
      if ($urandom_range(0, 1) == 0) wd = 32'($urandom_range(0, 15));
      else wd = $urandom;
      step(we, a, wd, 1'b1, 1'b0, 32'h0, "rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
